// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset datapath: decodes the IR
// fields, steps FETCH/DECODE/EXECUTE/MEM/WB and counts retired instructions.
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opCode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [1:0]           PcSel,
  output logic                 IorD,
  output logic                 MemReadEn,
  output logic                 MemWriteEn,
  output logic                 RegWriteEn,
  output logic [1:0]           RegDst,
  output logic [1:0]           MemtoReg,
  output logic                 ALUSrc,
  output logic [3:0]           ALUOp,
  output logic [3:0]           state,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_ALU   = 4'd7;
  localparam logic [3:0] S_WB_MEM   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h16;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_SGT = 6'h14;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_XOR = 6'h15;
  localparam logic [5:0] FN_JR  = 6'h08;

  logic [3:0]           r_state;
  logic                 r_illegal;
  logic [CNT_WIDTH-1:0] r_count;

  logic       w_isR;
  logic       w_functValid;
  logic [3:0] w_rAluOp;
  logic [3:0] w_iAluOp;
  logic       w_branchTaken;
  logic [3:0] w_next;
  logic       w_retire;
  logic       w_illegal;

  assign w_isR         = (opCode == OP_R);
  assign w_branchTaken = ((opCode == OP_BEQ) && zero) || ((opCode == OP_BNE) && !zero);

  // jr is a valid funct but uses no ALU operation, so it falls to the 0000 default.
  always_comb begin
    w_functValid = 1'b1;
    w_rAluOp     = 4'b0000;
    case (funct)
      FN_ADD:  w_rAluOp = 4'b0000;
      FN_SUB:  w_rAluOp = 4'b0001;
      FN_AND:  w_rAluOp = 4'b0010;
      FN_OR:   w_rAluOp = 4'b0011;
      FN_SLT:  w_rAluOp = 4'b0100;
      FN_SGT:  w_rAluOp = 4'b0101;
      FN_NOR:  w_rAluOp = 4'b0110;
      FN_XOR:  w_rAluOp = 4'b0111;
      FN_SLL:  w_rAluOp = 4'b1000;
      FN_SRL:  w_rAluOp = 4'b1001;
      FN_JR:   w_rAluOp = 4'b0000;
      default: w_functValid = 1'b0;
    endcase
  end

  always_comb begin
    w_iAluOp = 4'b0000;
    case (opCode)
      OP_ORI:  w_iAluOp = 4'b0011;
      OP_XORI: w_iAluOp = 4'b0111;
      default: w_iAluOp = 4'b0000;
    endcase
  end

  always_comb begin
    w_next    = S_FETCH;
    w_retire  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opCode)
          OP_R: begin
            if (w_functValid) w_next = S_EXEC_R;
            else              w_illegal = 1'b1;
          end
          OP_ADDI, OP_ORI, OP_XORI: w_next = S_EXEC_I;
          OP_LW, OP_SW:             w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           w_next = S_BRANCH;
          OP_JAL:                   w_next = S_JAL;
          default:                  w_illegal = 1'b1;
        endcase
      end
      S_EXEC_R: begin
        if (funct == FN_JR) w_retire = 1'b1;
        else                w_next = S_WB_ALU;
      end
      S_EXEC_I:   w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = (opCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: begin
        if (mem_ready) w_retire = 1'b1;
        else           w_next = S_MEM_WR;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: w_retire = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    PcSel      = 2'b00;
    IorD       = 1'b0;
    MemReadEn  = 1'b0;
    MemWriteEn = 1'b0;
    RegWriteEn = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    ALUSrc     = 1'b0;
    ALUOp      = 4'b0000;
    case (r_state)
      S_FETCH: begin
        MemReadEn = 1'b1;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_EXEC_R: begin
        ALUOp = w_rAluOp;
        if (funct == FN_JR) begin
          PCWrite = 1'b1;
          PcSel   = 2'b11;
        end
      end
      S_EXEC_I: begin
        ALUSrc = 1'b1;
        ALUOp  = w_iAluOp;
      end
      S_WB_ALU: begin
        RegWriteEn = 1'b1;
        RegDst     = w_isR ? 2'b01 : 2'b00;
        ALUSrc     = !w_isR;
        ALUOp      = w_isR ? w_rAluOp : w_iAluOp;
      end
      S_MEM_ADDR: ALUSrc = 1'b1;
      S_MEM_RD: begin
        MemReadEn = 1'b1;
        IorD      = 1'b1;
      end
      S_MEM_WR: begin
        MemWriteEn = 1'b1;
        IorD       = 1'b1;
      end
      S_WB_MEM: begin
        RegWriteEn = 1'b1;
        MemtoReg   = 2'b01;
      end
      S_BRANCH: begin
        ALUOp = 4'b0001;
        if (w_branchTaken) begin
          PCWrite = 1'b1;
          PcSel   = 2'b01;
        end
      end
      S_JAL: begin
        RegWriteEn = 1'b1;
        RegDst     = 2'b10;
        MemtoReg   = 2'b10;
        PCWrite    = 1'b1;
        PcSel      = 2'b10;
      end
      default: ;
    endcase
    // A reset arriving mid-instruction must not let any write strobe escape.
    if (rst) begin
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PcSel      = 2'b00;
      IorD       = 1'b0;
      MemReadEn  = 1'b0;
      MemWriteEn = 1'b0;
      RegWriteEn = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      ALUSrc     = 1'b0;
      ALUOp      = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_illegal;
      if (w_retire) r_count <= r_count + 1'b1;
    end
  end

  assign state       = r_state;
  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the team's MIPS-subset datapath (shared instruction/data memory, one ALU, register file).
- Decodes opCode/funct from the instruction register and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB states.
- Drives all datapath enables and mux selects, stalls on memory wait states, and counts retired instructions.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- opCode  in  6  IR[31:26], stable from DECODE until return to FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the current read/write this cycle
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC
- PcSel  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target, 11 rs (jr)
- IorD  out  1  memory address: 0 PC, 1 ALU result register
- MemReadEn  out  1  memory read strobe
- MemWriteEn  out  1  memory write strobe
- RegWriteEn  out  1  register file write
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALU, 01 memory data, 10 PC (link)
- ALUSrc  out  1  0 rt, 1 sign/zero-extended immediate
- ALUOp  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 0101 sgt, 0110 nor, 0111 xor, 1000 sll, 1001 srl
- state  out  4  current state, for debug
- illegal_op  out  1  one-cycle registered pulse on an undecodable instruction
- instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH

Behaviour:
- Opcodes: R 0x00, addi 0x08, lw 0x23, sw 0x2b, beq 0x04, bne 0x05, jal 0x03, ori 0x0d, xori 0x16.
- Functs: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2a, sgt 0x14, sll 0x00, srl 0x02, nor 0x27, xor 0x15, jr 0x08.
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10. Codes 11-15 are unused and go to FETCH.
- All outputs are decoded from the current state plus zero, mem_ready and IR fields. Every output not listed for a state is 0.
- Reset (rst=1 at an edge): state=FETCH, instr_count=0, illegal_op=0. While rst=1, all strobe and select outputs are forced to 0, so a mid-instruction reset never writes memory, registers or PC.
- FETCH:
  - MemReadEn=1, IorD=0.
  - mem_ready=0: hold in FETCH.
  - mem_ready=1: IRWrite=1, PCWrite=1, PcSel=00, then go to DECODE.
- DECODE: one cycle.
  - R with a valid funct -> EXEC_R.
  - addi/ori/xori -> EXEC_I.
  - lw/sw -> MEM_ADDR.
  - beq/bne -> BRANCH.
  - jal -> JAL.
  - Any other opcode, or an unknown funct with R: go to FETCH, illegal_op=1 next cycle, instr_count not incremented.
- EXEC_R:
  - ALUSrc=0, ALUOp from the funct table.
  - jr: PCWrite=1, PcSel=11, then FETCH (retire).
  - Other functs: WB_ALU.
- EXEC_I: ALUSrc=1; ALUOp is 0000 for addi, 0011 for ori, 0111 for xori; then WB_ALU.
- WB_ALU:
  - RegWriteEn=1, MemtoReg=00.
  - RegDst=01 for R, 00 for I-type.
  - ALUSrc and ALUOp held from the execute state.
  - Then FETCH (retire).
- MEM_ADDR: ALUSrc=1, ALUOp=0000; then MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemReadEn=1, IorD=1; hold until mem_ready=1, then WB_MEM.
- MEM_WR: MemWriteEn=1, IorD=1; hold until mem_ready=1, then FETCH (retire).
- WB_MEM: RegWriteEn=1, RegDst=00, MemtoReg=01; then FETCH (retire).
- BRANCH:
  - ALUSrc=0, ALUOp=0001.
  - PCWrite=1 and PcSel=01 iff (beq and zero=1) or (bne and zero=0).
  - Then FETCH (retire) whether taken or not.
- JAL:
  - RegWriteEn=1, RegDst=10, MemtoReg=10; the link value is the already-incremented PC.
  - PCWrite=1, PcSel=10.
  - Then FETCH (retire).
- Retire: instr_count increments by 1 on the edge leaving a retire state. It wraps from all-ones to 0.
- Latency with mem_ready=1 throughout:
  - R/I ALU: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne/jal/jr: 3 cycles
  - Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

Test Plan:
- Reset, then add (op 0x00, funct 0x20) with mem_ready=1 -> states 0,1,2,7,0. RegWriteEn=1 with RegDst=01 only in cycle 4; instr_count=1.
- lw (0x23) with mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, MemReadEn=1 and IorD=1 throughout. WB_MEM gives RegWriteEn=1, MemtoReg=01; total 8 cycles.
- beq with zero=1, then bne with zero=1 -> first: PCWrite=1, PcSel=01 in BRANCH; second: PCWrite=0. instr_count increases by 2.
- jal (0x03) then jr (0x00/0x08) -> JAL: RegDst=10, MemtoReg=10, PCWrite=1, PcSel=10. jr: PCWrite=1, PcSel=11, RegWriteEn never 1.
- Opcode 0x3f, then R with funct 0x3e -> each returns DECODE->FETCH, illegal_op pulses 1 cycle, instr_count unchanged.
- rst=1 during MEM_WR with mem_ready=0 -> MemWriteEn=0 that cycle, state=0 next edge, instr_count=0. Preload the count to all-ones and retire one instruction -> instr_count wraps to 0.
